// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state encoding, widths and helpers for the FIR MAC sequencer
//
// Purpose : common definitions imported by fir_tap_counter and fir_mac_sequencer.
// Contents: FIR_ACC_W  default accumulator / result width
//           S_*        raw state encodings (kept as plain constants for legacy users)
//           fir_state_e sequencer state type built on those encodings
//           addr_w()   address width needed to index a given number of taps
package fir_pkg;

  localparam int FIR_ACC_W = 40;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_MAC   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  typedef enum logic [2:0] {
    ST_INIT  = S_INIT,
    ST_IDLE  = S_IDLE,
    ST_MAC   = S_MAC,
    ST_DRAIN = S_DRAIN,
    ST_CAPT  = S_CAPT,
    ST_OUT   = S_OUT
  } fir_state_e;

  // Smallest width w with 2**w >= ntaps, never below 1 so a port is always legal.
  function automatic int addr_w(input int ntaps);
    int w;
    w = 0;
    while ((1 << w) < ntaps) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// rtl/fir_tap_counter.sv - W-bit up counter with clear, enable and terminal-count flag
//
// Purpose : index generator used by the sequencer for both the delay-line
//           zero-fill index and the tap index. Wraps naturally to 0 after
//           the all-ones value, so a full pass leaves it ready for the next.
// Ports   : i_clk    rising-edge clock
//           i_rst_n  asynchronous active-low reset (count -> 0)
//           i_clr    synchronous clear, wins over i_en
//           i_en     advance by one
//           o_count  current count
//           o_tc     high while the count is at its last value (all ones)
module fir_tap_counter
  import fir_pkg::*;
#(
  parameter int W = addr_w(16)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = &r_count;

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - control sequencer for a time-multiplexed single-MAC FIR datapath
//
// Purpose : accepts one sample per handshake, zero-fills the circular delay
//           line after reset/flush, walks every tap through the shared MAC
//           and captures the accumulator into a handshaked output register.
//           No arithmetic lives here; RAM, ROM and MAC sit beside this block.
// Ports   : i_clk          rising-edge clock
//           i_rst_n        asynchronous active-low reset
//           i_flush        re-zero request, honoured only in IDLE
//           i_in_valid     sample offered      / o_in_ready   sample taken
//           o_dl_wr_en     delay-line write    / o_dl_wr_zero write 0 instead of sample
//           o_dl_wr_addr   delay-line write address
//           o_dl_rd_addr   delay-line read address (1-cycle read latency)
//           o_coef_addr    coefficient ROM address (1-cycle read latency)
//           o_mac_en       MAC consumes the current read data
//           o_mac_clr      with o_mac_en: load product instead of accumulating
//           i_acc_in       registered accumulator from the datapath
//           o_out_valid    result available    / i_out_ready  result taken
//           o_out_data     captured result, held while o_out_valid
//           o_busy         high in every state except IDLE
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int NTAPS = 16,
  parameter  int ACC_W = FIR_ACC_W,
  localparam int AW    = addr_w(NTAPS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_dl_wr_en,
  output logic             o_dl_wr_zero,
  output logic [AW-1:0]    o_dl_wr_addr,
  output logic [AW-1:0]    o_dl_rd_addr,
  output logic [AW-1:0]    o_coef_addr,
  output logic             o_mac_en,
  output logic             o_mac_clr,
  input  logic [ACC_W-1:0] i_acc_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [ACC_W-1:0] o_out_data,
  output logic             o_busy
);

  fir_state_e       r_state;
  fir_state_e       w_state_nxt;

  logic [AW-1:0]    r_wptr;
  logic             r_mac_en;
  logic             r_mac_clr;
  logic [ACC_W-1:0] r_out_data;

  logic [AW-1:0]    w_init_idx;
  logic             w_init_tc;
  logic [AW-1:0]    w_tap_idx;
  logic             w_tap_tc;

  logic             w_in_init;
  logic             w_in_idle;
  logic             w_in_mac;
  logic             w_flush_req;
  logic             w_accept;

  assign w_in_init   = (r_state == ST_INIT);
  assign w_in_idle   = (r_state == ST_IDLE);
  assign w_in_mac    = (r_state == ST_MAC);

  // Flush outranks a simultaneous sample, so the handshake is withheld that cycle.
  assign w_flush_req = w_in_idle & i_flush;
  assign w_accept    = w_in_idle & ~i_flush & i_in_valid;

  // Zero-fill index; it wraps back to 0 on the last write so a later flush
  // starts from 0 as well, the clear only guards that invariant.
  fir_tap_counter #(
    .W (AW)
  ) u_init_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_flush_req),
    .i_en    (w_in_init),
    .o_count (w_init_idx),
    .o_tc    (w_init_tc)
  );

  // Tap index k, restarted on every accepted sample.
  fir_tap_counter #(
    .W (AW)
  ) u_tap_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_accept),
    .i_en    (w_in_mac),
    .o_count (w_tap_idx),
    .o_tc    (w_tap_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  if (w_init_tc) w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (i_flush) begin
          w_state_nxt = ST_INIT;
        end else if (i_in_valid) begin
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC:   if (w_tap_tc) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_CAPT;
      ST_CAPT:  w_state_nxt = ST_OUT;
      ST_OUT:   if (i_out_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write pointer: newest sample slot. Re-zeroing the line also rewinds it;
  // it advances only once the result has been handed off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
    end else if (w_in_init) begin
      r_wptr <= '0;
    end else if ((r_state == ST_OUT) && i_out_ready) begin
      r_wptr <= r_wptr + 1'b1;
    end
  end

  // Read data and coefficient arrive one cycle after the address, so the MAC
  // strobes trail the issue by one cycle; the first tap loads instead of adds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      r_mac_en  <= w_in_mac;
      r_mac_clr <= w_in_mac && (w_tap_idx == '0);
    end
  end

  // Accumulator is registered in the datapath: after the last mac_en in DRAIN
  // it holds the final sum during CAPT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data <= '0;
    end else if (r_state == ST_CAPT) begin
      r_out_data <= i_acc_in;
    end
  end

  assign o_in_ready   = w_in_idle & ~i_flush;

  // INIT is also the reset state; gating with the reset input keeps the RAM
  // from being written while reset is still asserted.
  assign o_dl_wr_en   = (w_in_init & i_rst_n) | w_accept;
  assign o_dl_wr_zero = w_in_init;
  assign o_dl_wr_addr = w_in_init ? w_init_idx : r_wptr;

  // Tap k reads the sample k steps older than the newest; AW-bit wrap gives
  // the circular indexing for free.
  assign o_dl_rd_addr = r_wptr - w_tap_idx;
  assign o_coef_addr  = w_tap_idx;

  assign o_mac_en     = r_mac_en;
  assign o_mac_clr    = r_mac_clr;
  assign o_out_valid  = (r_state == ST_OUT);
  assign o_out_data   = r_out_data;
  assign o_busy       = ~w_in_idle;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed self-checking bench for fir_mac_sequencer
module tb_fir_mac_sequencer;
  import fir_pkg::*;

  localparam int NTAPS = 16;
  localparam int ACC_W = 40;
  localparam int AW    = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             flush     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic [15:0]      x_in      = 16'd0;

  logic             in_ready;
  logic             dl_wr_en;
  logic             dl_wr_zero;
  logic [AW-1:0]    dl_wr_addr;
  logic [AW-1:0]    dl_rd_addr;
  logic [AW-1:0]    coef_addr;
  logic             mac_en;
  logic             mac_clr;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             busy;
  logic [ACC_W-1:0] acc = '0;

  int               n_asserts = 0;
  int               n_fail    = 0;
  logic [AW-1:0]    exp_wptr  = '0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(
    .NTAPS (NTAPS),
    .ACC_W (ACC_W)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .o_dl_wr_en   (dl_wr_en),
    .o_dl_wr_zero (dl_wr_zero),
    .o_dl_wr_addr (dl_wr_addr),
    .o_dl_rd_addr (dl_rd_addr),
    .o_coef_addr  (coef_addr),
    .o_mac_en     (mac_en),
    .o_mac_clr    (mac_clr),
    .i_acc_in     (acc),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_out_data   (out_data),
    .o_busy       (busy)
  );

  // Behavioural datapath: delay-line RAM, ROM c[k] = k+1, registered MAC.
  logic [15:0] dl_mem [NTAPS];
  logic [15:0] rd_q = '0;
  logic [15:0] cf_q = '0;

  always @(posedge clk) begin
    if (dl_wr_en) dl_mem[dl_wr_addr] <= dl_wr_zero ? 16'd0 : x_in;
    rd_q <= dl_mem[dl_rd_addr];
    cf_q <= 16'(coef_addr) + 16'd1;
    if (mac_en) acc <= (mac_clr ? '0 : acc) + ACC_W'(rd_q) * ACC_W'(cf_q);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered during zero-fill cycle 0; leaves at the first IDLE cycle.
  task automatic chk_init(input string tag);
    for (int i = 0; i < NTAPS; i++) begin
      chk($sformatf("%s_i%0d", tag, i),
          64'({dl_wr_en, dl_wr_zero, in_ready, busy, out_valid, dl_wr_addr}),
          64'({5'b11010, AW'(i)}));
      @(negedge clk);
    end
    chk($sformatf("%s_idle", tag), 64'({in_ready, busy, dl_wr_en}), 64'(3'b100));
    exp_wptr = '0;
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE after the handoff.
  task automatic run_sample(input logic [15:0] x, input int hold,
                            input logic [ACC_W-1:0] exp, input int id);
    chk($sformatf("s%0d_rdy", id), 64'({in_ready, busy}), 64'(2'b10));
    x_in = x;
    in_valid = 1'b1;
    #1;
    chk($sformatf("s%0d_wr", id), 64'({dl_wr_en, dl_wr_zero, dl_wr_addr}),
        64'({2'b10, exp_wptr}));
    for (int c = 1; c <= NTAPS + 3; c++) begin
      @(negedge clk);
      if (c <= NTAPS)
        chk($sformatf("s%0d_addr_c%0d", id, c), 64'({dl_rd_addr, coef_addr}),
            64'({exp_wptr - AW'(c - 1), AW'(c - 1)}));
      chk($sformatf("s%0d_ctl_c%0d", id, c),
          64'({mac_en, mac_clr, out_valid, in_ready, dl_wr_en}),
          64'({1'(c >= 2 && c <= NTAPS + 1), 1'(c == 2), 1'(c == NTAPS + 3), 2'b00}));
    end
    chk($sformatf("s%0d_out", id), 64'(out_data), 64'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk($sformatf("s%0d_bp%0d", id, h), 64'({out_valid, in_ready, dl_wr_en, out_data}),
          64'({3'b100, exp}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk($sformatf("s%0d_done", id), 64'({out_valid, in_ready, busy}), 64'(3'b010));
    exp_wptr = exp_wptr + 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctl", 64'({dl_wr_en, in_ready, busy, out_valid, mac_en, mac_clr}), 64'(6'b001000));
    chk("rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    #1;
    chk_init("init_rst");

    // Impulse response; sample 16 lands on wptr 0 after the wrap.
    for (int n = 0; n <= NTAPS; n++)
      run_sample(16'(n == 0 ? 1 : 0), (n == 3) ? 10 : 0,
                 ACC_W'(n < NTAPS ? n + 1 : 0), n);

    // Leave a non-zero sample in the line so the flush has something to erase.
    run_sample(16'd5, 0, ACC_W'(5), 100);

    flush    = 1'b1;
    in_valid = 1'b1;
    x_in     = 16'd7;
    #1;
    chk("flush_block", 64'({in_ready, dl_wr_en, busy}), 64'(3'b000));
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_init("init_flush");
    for (int n = 0; n < NTAPS; n++)
      run_sample(16'(n == 0 ? 1 : 0), 0, ACC_W'(n + 1), 200 + n);

    // Reset in the middle of the MAC walk.
    x_in     = 16'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_mac_live", 64'({mac_en, busy}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 64'({mac_en, out_valid, in_ready, busy, dl_wr_en}), 64'(5'b00010));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_init("init_rerun");
    for (int c = 0; c < NTAPS + 4; c++) begin
      chk($sformatf("no_stale_%0d", c), 64'({out_valid, in_ready}), 64'(2'b01));
      @(negedge clk);
    end
    run_sample(16'd1, 0, ACC_W'(1), 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control sequencer for the time-multiplexed FIR datapath: one shared multiply-accumulate unit, a circular sample delay-line RAM and a coefficient ROM. It accepts one input sample per valid/ready handshake, zero-fills the delay line after reset or flush, and walks all taps through the MAC. It then captures the accumulator into an output register with its own valid/ready handshake. It contains no arithmetic; the datapath sits beside it and receives its strobes and addresses.

## Interface
- NTAPS, 16, number of taps; power of two, ≥ 2
- ACC_W, 40, accumulator/output width
- AW, $clog2(NTAPS), address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  sync request to re-zero delay line; sampled only in IDLE
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid & in_ready
- dl_wr_en  out  1  delay-line write strobe
- dl_wr_zero  out  1  write data is 0 (else input sample)
- dl_wr_addr  out  AW  delay-line write address
- dl_rd_addr  out  AW  delay-line read address (1-cycle read latency)
- coef_addr  out  AW  coefficient ROM address (1-cycle read latency)
- mac_en  out  1  MAC consumes current read data
- mac_clr  out  1  with mac_en: acc = product (no add)
- acc_in  in  ACC_W  datapath accumulator (registered, valid cycle after mac_en)
- out_valid  out  1  filtered result available
- out_ready  in  1  consumer takes result
- out_data  out  ACC_W  captured result
- busy  out  1  high in any state but IDLE

## Operation
- States: INIT, IDLE, MAC, DRAIN, CAPT, OUT.
- INIT: counter i = 0..NTAPS-1; dl_wr_en=1, dl_wr_zero=1, dl_wr_addr=i; → IDLE after i=NTAPS-1; wptr=0.
- IDLE: in_ready=1. flush=1 → INIT (flush has priority over in_valid in the same cycle; sample not accepted). in_valid → dl_wr_en=1, dl_wr_zero=0, dl_wr_addr=wptr (combinational, same cycle); k=0; → MAC.
- MAC: issue tap k: dl_rd_addr=(wptr−k) mod NTAPS (natural AW-bit wrap), coef_addr=k; k++; after k=NTAPS-1 → DRAIN.
- mac_en = issue registered by one cycle; mac_clr = mac_en for k=0 only.
- DRAIN: last mac_en fires; → CAPT.
- CAPT: out_data ← acc_in; → OUT.
- OUT: out_valid=1; on out_ready → wptr ← wptr+1, IDLE. out_data stable while out_valid=1.
- in_ready=0 outside IDLE; flush ignored outside IDLE.

## Timing
- Reset values: state=INIT, i=0, k=0, wptr=0, in_ready=0, out_valid=0, out_data=0, mac_en=0, mac_clr=0, dl_wr_en=0 during reset, busy=1.
- INIT occupies NTAPS cycles after reset release; in_ready first high NTAPS cycles after release.
- Accept at cycle 0: issues in cycles 1..NTAPS, mac_en cycles 2..NTAPS+1, CAPT cycle NTAPS+2, out_valid from cycle NTAPS+3.
- Throughput: one sample per NTAPS+4 cycles, plus any out_ready back-pressure.
- Reset asserted mid-operation: immediate return to reset values; result discarded; INIT reruns.
- wptr wraps NTAPS-1 → 0.

## Structure
- Shared package fir_pkg: state enum (INIT, IDLE, MAC, DRAIN, CAPT, OUT), addr_w(ntaps) function, default ACC_W constant.
- One sub-module: fir_tap_counter (AW-bit counter with clear, enable and terminal-count flag), instanced for both the INIT index and the tap index k.
- Datapath (RAM, ROM, MAC) is not part of this block; the bench supplies a behavioural model.

## Test plan
- Reset release, NTAPS=16 → dl_wr_en/dl_wr_zero high 16 cycles, addresses 0..15, in_ready rises at cycle 16.
- Impulse: coefs c[k]=k+1, inputs 1,0,0,0… → outputs 1,2,3,…,16, then 0; each out_valid exactly NTAPS+3 cycles after accept.
- Read-address wrap: the 17th sample (wptr=0 after wrap) → dl_rd_addr sequence 0,15,14,…,1; mac_clr only on first mac_en.
- Back-pressure: out_ready held low 10 cycles → out_valid and out_data stable, in_ready=0 throughout, next accept only after handshake.
- Flush and in_valid together in IDLE → sample not accepted, 16 zero writes, wptr=0; next impulse reproduces the response 1..16.
- Reset asserted in the middle of the MAC state → mac_en, out_valid and in_ready low at once; INIT reruns; no stale out_valid.
